perf_counter_mc: RTL and testbench
==================================

// Module: perf_counter_mc
// PURPOSE
//  Synthesizable multi-channel performance monitor that watches the CPU program counter.
//  - Counts total cycles, plus cycles spent inside NUM_CHANNELS programmable PC windows.
//  - Detects the end-of-program PC and a stalled PC (hang).
//  - Shows the selected counter on HEX0..HEX2 and status on LED.
//  - Sits beside the CPU at top level: pc tapped from CPU, SW from board switches.
// PARAMETERS
//  PC_WIDTH      16       width of pc and of window bounds
//  CNT_WIDTH     32       width of every counter (>=12)
//  NUM_CHANNELS  4        number of PC-window channels (1..7)
//  FINAL_PC      16'd1023 pc value that ends the run (compared as PC_WIDTH bits)
//  STALL_LIMIT   1024     consecutive unchanged-pc cycles that declare a stall (>=2)
// PORTS
//  CLK_50     in   1          system clock, all logic on rising edge
//  reset      in   1          asynchronous, active-high reset
//  pc         in   PC_WIDTH   CPU program counter, sampled every cycle
//  clear      in   1          sync: zero all counters, re-enter RUN
//  cfg_we     in   1          sync: write window of channel cfg_sel
//  cfg_sel    in   3          channel index for cfg_we (>=NUM_CHANNELS ignored)
//  cfg_lo     in   PC_WIDTH   window lower bound, inclusive
//  cfg_hi     in   PC_WIDTH   window upper bound, inclusive
//  SW         in   4          SW[2:0] display select; SW[3]=1 shows bits [23:12] instead of [11:0]
//  rd_count   out  CNT_WIDTH  counter selected by SW[2:0] (combinational mux of registers)
//  HEX0..2    out  7 each     active-low 7-seg hex digits, HEX0 = least significant nibble
//  LED        out  10         [0]=RUN [1]=DONE [2]=STALLED [9:3]=0
//  finished   out  1          high in DONE or STALLED
// BEHAVIOUR
//  Reset values:
//   - state=RUN; all counters, pc_q and stall_cnt = 0.
//   - Windows lo = all-ones, hi = 0, so every channel is empty.
//   - HEX0..2 = 7'h7F (blank), LED = 10'b0000000001, finished = 0.
//  States: RUN, DONE, STALLED.
//   - RUN -> DONE when pc == FINAL_PC.
//   - RUN -> STALLED when stall_cnt reaches STALL_LIMIT-1 and pc == pc_q.
//   - FINAL_PC check wins over stall in the same cycle.
//   - DONE/STALLED -> RUN only on clear. Reset returns to RUN from any state, any cycle.
//  Counting, RUN only (DONE/STALLED freeze all counters):
//   - cycle_cnt += 1 every cycle.
//   - chan_cnt[k] += 1 when lo[k] <= pc <= hi[k], unsigned compare. lo>hi means empty window.
//   - All counters saturate at all-ones; no wrap.
//   - The cycle that transitions RUN->DONE/STALLED is still counted.
//  Stall tracking:
//   - pc_q <= pc every cycle.
//   - stall_cnt <= (pc == pc_q) ? stall_cnt+1 : 0, saturating at STALL_LIMIT-1.
//   - stall_cnt is cleared by clear.
//  Configuration:
//   - cfg_we writes lo/hi of channel cfg_sel and zeroes that channel's counter.
//   - The new window applies from the next cycle.
//   - Allowed in any state; does not change state.
//  Priority within a cycle: reset > clear > cfg_we > count.
//   - clear zeroes all counters (windows kept), pc_q <= pc, state <= RUN.
//   - clear and cfg_we together: both take effect.
//  Display:
//   - SW[2:0] < NUM_CHANNELS selects chan_cnt.
//   - SW[2:0] == NUM_CHANNELS selects cycle_cnt.
//   - Any other SW[2:0] selects 0.
//   - HEX digits are registered: 1-cycle latency from the counter or SW change.
//   - Hex font: standard 0-F, segment g = bit 6, active-low.
//  finished and LED are registered from state: asserted the cycle after the transition edge.
// TESTING
//  1. Reset, pc=0 held 5 cyc, SW=4 (NUM_CHANNELS=4) -> cycle_cnt=5; HEX0 shows '5' one cycle later; LED=1, finished=0.
//  2. cfg ch0 lo=100 hi=199, pc sweeps 90..209 one step/cycle -> chan_cnt[0]=100 exactly, then pc=1023 -> finished=1 next cycle, counters frozen.
//  3. pc held at 50, STALL_LIMIT=16 -> STALLED entered after 16 equal-pc samples, LED[2]=1; pc change afterwards keeps STALLED; clear -> RUN, counts=0.
//  4. CNT_WIDTH=12, run 5000 cycles -> cycle_cnt=12'hFFF, HEX2..0 show 'FFF', no wrap.
//  5. cfg_we on ch1 while it is counting (value 37) and pc inside -> cnt becomes 0, counts 1 next cycle; same-cycle clear+cfg_we -> all zero, new window kept.
//  6. Assert reset mid-run in DONE with nonzero counts -> all outputs at reset values immediately (async), resumes RUN after release.

Source files
------------

// File: rtl/perf_counter_mc.sv
// perf_counter_mc
//   Performance monitor placed beside the CPU. Counts total cycles and cycles spent inside
//   NUM_CHANNELS programmable PC windows, detects the end-of-program PC (DONE) and a PC that
//   stops changing (STALLED), and shows a selected counter on three 7-segment digits.
// Ports
//   CLK_50    : system clock, rising edge
//   reset     : asynchronous active-high reset
//   pc        : CPU program counter, sampled every cycle
//   clear     : zero all counters and return to RUN (windows kept)
//   cfg_we    : write window cfg_lo..cfg_hi into channel cfg_sel and zero its counter
//   cfg_sel   : channel index for cfg_we; values >= NUM_CHANNELS are ignored
//   cfg_lo/hi : inclusive window bounds
//   SW        : [2:0] display select, [3] shows bits [23:12] instead of [11:0]
//   rd_count  : counter selected by SW[2:0], combinational
//   HEX0..2   : registered active-low hex digits, HEX0 = least significant nibble
//   LED       : [0]=RUN [1]=DONE [2]=STALLED, registered
//   finished  : registered, high in DONE or STALLED
module perf_counter_mc #(
   parameter int unsigned         PC_WIDTH     = 16,
   parameter int unsigned         CNT_WIDTH    = 32,
   parameter int unsigned         NUM_CHANNELS = 4,
   parameter logic [PC_WIDTH-1:0] FINAL_PC     = 16'd1023,
   parameter int unsigned         STALL_LIMIT  = 1024
) (
   input  logic                 CLK_50,
   input  logic                 reset,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic                 clear,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_sel,
   input  logic [PC_WIDTH-1:0]  cfg_lo,
   input  logic [PC_WIDTH-1:0]  cfg_hi,
   input  logic [3:0]           SW,
   output logic [CNT_WIDTH-1:0] rd_count,
   output logic [6:0]           HEX0,
   output logic [6:0]           HEX1,
   output logic [6:0]           HEX2,
   output logic [9:0]           LED,
   output logic                 finished
);

   localparam int unsigned          StallW   = $clog2(STALL_LIMIT);
   localparam logic [StallW-1:0]    StallMax = StallW'(STALL_LIMIT - 1);
   localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

   typedef enum logic [1:0] {StRun, StDone, StStalled} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
   logic [CNT_WIDTH-1:0] chan_q [NUM_CHANNELS];
   logic [CNT_WIDTH-1:0] chan_d [NUM_CHANNELS];
   logic [PC_WIDTH-1:0]  lo_q   [NUM_CHANNELS];
   logic [PC_WIDTH-1:0]  lo_d   [NUM_CHANNELS];
   logic [PC_WIDTH-1:0]  hi_q   [NUM_CHANNELS];
   logic [PC_WIDTH-1:0]  hi_d   [NUM_CHANNELS];
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [StallW-1:0]    stall_q, stall_d;
   logic [6:0]           hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;
   logic [9:0]           led_q, led_d;
   logic                 finished_q, finished_d;
   logic                 pc_same;
   logic [23:0]          disp;
   logic [11:0]          disp_field;

   // Active-low segments, g = bit 6.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      unique case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign pc_same = (pc == pc_q);

   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      pc_d    = pc;
      for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
         chan_d[k] = chan_q[k];
         lo_d[k]   = lo_q[k];
         hi_d[k]   = hi_q[k];
      end

      if (!pc_same) begin
         stall_d = '0;
      end else if (stall_q != StallMax) begin
         stall_d = stall_q + 1'b1;
      end else begin
         stall_d = stall_q;
      end

      // The cycle that leaves RUN is still counted.
      if (state_q == StRun) begin
         if (cycle_q != CntMax) cycle_d = cycle_q + 1'b1;
         for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
            if ((pc >= lo_q[k]) && (pc <= hi_q[k]) && (chan_q[k] != CntMax)) begin
               chan_d[k] = chan_q[k] + 1'b1;
            end
         end
         if (pc == FINAL_PC) begin
            state_d = StDone;
         end else if (pc_same && (stall_q == StallMax)) begin
            state_d = StStalled;
         end
      end

      if (clear) begin
         state_d = StRun;
         cycle_d = '0;
         stall_d = '0;
         for (int k = 0; k < int'(NUM_CHANNELS); k++) chan_d[k] = '0;
      end

      for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
         if (cfg_we && (cfg_sel == 3'(k))) begin
            lo_d[k]   = cfg_lo;
            hi_d[k]   = cfg_hi;
            chan_d[k] = '0;
         end
      end
   end

   always_comb begin
      rd_count = '0;
      for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
         if (SW[2:0] == 3'(k)) rd_count = chan_q[k];
      end
      if (SW[2:0] == 3'(NUM_CHANNELS)) rd_count = cycle_q;
   end

   // Narrow counters read as zero in the upper display field.
   generate
      if (CNT_WIDTH >= 24) begin : g_disp_trunc
         assign disp = rd_count[23:0];
      end else begin : g_disp_ext
         assign disp = {{(24 - CNT_WIDTH){1'b0}}, rd_count};
      end
   endgenerate

   assign disp_field = SW[3] ? disp[23:12] : disp[11:0];

   always_comb begin
      hex0_d     = seg7(disp_field[3:0]);
      hex1_d     = seg7(disp_field[7:4]);
      hex2_d     = seg7(disp_field[11:8]);
      led_d      = {7'b0, state_d == StStalled, state_d == StDone, state_d == StRun};
      finished_d = (state_d != StRun);
   end

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         state_q    <= StRun;
         cycle_q    <= '0;
         pc_q       <= '0;
         stall_q    <= '0;
         hex0_q     <= 7'h7F;
         hex1_q     <= 7'h7F;
         hex2_q     <= 7'h7F;
         led_q      <= 10'b00_0000_0001;
         finished_q <= 1'b0;
         for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
            chan_q[k] <= '0;
            lo_q[k]   <= '1;
            hi_q[k]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         cycle_q    <= cycle_d;
         pc_q       <= pc_d;
         stall_q    <= stall_d;
         hex0_q     <= hex0_d;
         hex1_q     <= hex1_d;
         hex2_q     <= hex2_d;
         led_q      <= led_d;
         finished_q <= finished_d;
         for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
            chan_q[k] <= chan_d[k];
            lo_q[k]   <= lo_d[k];
            hi_q[k]   <= hi_d[k];
         end
      end
   end

   assign HEX0     = hex0_q;
   assign HEX1     = hex1_q;
   assign HEX2     = hex2_q;
   assign LED      = led_q;
   assign finished = finished_q;

endmodule

// File: tb/tb_perf_counter_mc.sv
// Bench for perf_counter_mc: directed vector table, hand sequences for stall, done, saturation
// and async reset, then randomized traffic against a behavioural model.
module tb_perf_counter_mc;

   localparam int unsigned NumCh    = 4;
   localparam int unsigned StallLim = 16;
   localparam logic [15:0] FinalPc  = 16'd1023;
   localparam longint      CntMax   = 64'hFFFF_FFFF;
   // Active-high segment patterns gfedcba for digits 0..F.
   localparam logic [6:0]  FontOn [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                           7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E,
                                           7'h79, 7'h71};

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc;
   logic        clear, cfg_we;
   logic [2:0]  cfg_sel;
   logic [15:0] cfg_lo, cfg_hi;
   logic [3:0]  sw;
   logic [31:0] rd_count;
   logic [6:0]  hex0, hex1, hex2;
   logic [9:0]  led;
   logic        finished;
   logic [11:0] s_rd;
   logic [6:0]  s_hex0, s_hex1, s_hex2;
   logic [9:0]  s_led;
   logic        s_fin;

   always #5 clk = ~clk;

   perf_counter_mc #(
      .PC_WIDTH(16), .CNT_WIDTH(32), .NUM_CHANNELS(NumCh), .FINAL_PC(FinalPc),
      .STALL_LIMIT(StallLim)
   ) dut (
      .CLK_50(clk), .reset(reset), .pc(pc), .clear(clear), .cfg_we(cfg_we),
      .cfg_sel(cfg_sel), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .SW(sw), .rd_count(rd_count),
      .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .LED(led), .finished(finished)
   );

   perf_counter_mc #(
      .PC_WIDTH(16), .CNT_WIDTH(12), .NUM_CHANNELS(NumCh), .FINAL_PC(FinalPc),
      .STALL_LIMIT(StallLim)
   ) dut_sat (
      .CLK_50(clk), .reset(reset), .pc(pc), .clear(clear), .cfg_we(cfg_we),
      .cfg_sel(cfg_sel), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .SW(sw), .rd_count(s_rd),
      .HEX0(s_hex0), .HEX1(s_hex1), .HEX2(s_hex2), .LED(s_led), .finished(s_fin)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] hexd(input logic [3:0] d);
      return ~FontOn[d];
   endfunction

   // Behavioural model: state 0=RUN 1=DONE 2=STALLED.
   longint      m_cycle;
   longint      m_chan [NumCh];
   logic [15:0] m_lo [NumCh];
   logic [15:0] m_hi [NumCh];
   logic [15:0] m_last;
   int          m_state, m_streak;
   logic [6:0]  m_h0, m_h1, m_h2;

   task automatic model_reset();
      m_cycle = 0; m_state = 0; m_streak = 0; m_last = '0;
      m_h0 = 7'h7F; m_h1 = 7'h7F; m_h2 = 7'h7F;
      for (int k = 0; k < NumCh; k++) begin
         m_chan[k] = 0; m_lo[k] = 16'hFFFF; m_hi[k] = 16'h0;
      end
   endtask

   function automatic logic [31:0] model_sel(input logic [3:0] s);
      if (int'(s[2:0]) < NumCh) return 32'(m_chan[s[1:0]]);
      if (int'(s[2:0]) == NumCh) return 32'(m_cycle);
      return 32'd0;
   endfunction

   // Called at the clock edge while the applied inputs are still stable.
   task automatic model_step();
      logic [31:0] v;
      logic [11:0] f;
      bit          eq;
      v    = model_sel(sw);
      f    = sw[3] ? v[23:12] : v[11:0];
      m_h0 = hexd(f[3:0]); m_h1 = hexd(f[7:4]); m_h2 = hexd(f[11:8]);
      eq   = (pc == m_last);
      if (clear) begin
         m_cycle = 0; m_state = 0; m_streak = 0;
         for (int k = 0; k < NumCh; k++) m_chan[k] = 0;
      end else begin
         if (m_state == 0) begin
            if (m_cycle < CntMax) m_cycle++;
            for (int k = 0; k < NumCh; k++)
               if (pc >= m_lo[k] && pc <= m_hi[k] && m_chan[k] < CntMax) m_chan[k]++;
            if (pc == FinalPc) m_state = 1;
            else if (eq && m_streak >= int'(StallLim) - 1) m_state = 2;
         end
         m_streak = eq ? m_streak + 1 : 0;
      end
      if (cfg_we && int'(cfg_sel) < NumCh) begin
         m_chan[cfg_sel[1:0]] = 0; m_lo[cfg_sel[1:0]] = cfg_lo; m_hi[cfg_sel[1:0]] = cfg_hi;
      end
      m_last = pc;
   endtask

   task automatic model_check();
      logic [9:0] el;
      el = (m_state == 0) ? 10'd1 : (m_state == 1) ? 10'd2 : 10'd4;
      check("rnd_rd_count", rd_count, model_sel(sw));
      check("rnd_hex0", 32'(hex0), 32'(m_h0));
      check("rnd_hex1", 32'(hex1), 32'(m_h1));
      check("rnd_hex2", 32'(hex2), 32'(m_h2));
      check("rnd_led", 32'(led), 32'(el));
      check("rnd_finished", 32'(finished), 32'(m_state != 0));
   endtask

   task automatic drive(input logic [15:0] p, input logic c, input logic w, input logic [2:0] s,
                        input logic [15:0] l, input logic [15:0] h, input logic [3:0] sws);
      pc = p; clear = c; cfg_we = w; cfg_sel = s; cfg_lo = l; cfg_hi = h; sw = sws;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic tick(input logic [15:0] p, input logic [3:0] sws);
      drive(p, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0, sws);
   endtask

   typedef struct {
      logic [15:0] pc;
      logic        clr;
      logic        we;
      logic [2:0]  sel;
      logic [15:0] lo;
      logic [15:0] hi;
      logic [3:0]  sw;
      logic [31:0] exp_cnt;
      logic [3:0]  exp_dig;
      logic [9:0]  exp_led;
   } vec_t;

   vec_t        vecs [15];
   logic [15:0] rp, last_p;
   int          hold_left;
   logic        rc, rw;

   initial begin
      vecs[0]  = '{16'd0,  1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd4,  32'd1,  4'h0, 10'd1};
      vecs[1]  = '{16'd0,  1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd4,  32'd2,  4'h1, 10'd1};
      vecs[2]  = '{16'd0,  1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd4,  32'd3,  4'h2, 10'd1};
      vecs[3]  = '{16'd0,  1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd4,  32'd4,  4'h3, 10'd1};
      vecs[4]  = '{16'd0,  1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd4,  32'd5,  4'h4, 10'd1};
      vecs[5]  = '{16'd1,  1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd4,  32'd6,  4'h5, 10'd1};
      vecs[6]  = '{16'd2,  1'b0, 1'b1, 3'd1, 16'd10, 16'd20,  4'd1,  32'd0,  4'h0, 10'd1};
      vecs[7]  = '{16'd12, 1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd1,  32'd1,  4'h0, 10'd1};
      vecs[8]  = '{16'd13, 1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd1,  32'd2,  4'h1, 10'd1};
      vecs[9]  = '{16'd30, 1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd1,  32'd2,  4'h2, 10'd1};
      vecs[10] = '{16'd14, 1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd5,  32'd0,  4'h0, 10'd1};
      vecs[11] = '{16'd14, 1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd4,  32'd12, 4'hB, 10'd1};
      vecs[12] = '{16'd15, 1'b0, 1'b1, 3'd7, 16'd0,  16'd100, 4'd0,  32'd0,  4'h0, 10'd1};
      vecs[13] = '{16'd16, 1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd12, 32'd14, 4'h0, 10'd1};
      vecs[14] = '{16'd17, 1'b0, 1'b0, 3'd0, 16'd0,  16'd0,   4'd3,  32'd0,  4'h0, 10'd1};

      reset = 1'b1; pc = '0; clear = 1'b0; cfg_we = 1'b0; cfg_sel = '0;
      cfg_lo = '0; cfg_hi = '0; sw = 4'd4;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd_count", rd_count, 32'd0);
      check("reset_hex0", 32'(hex0), 32'h7F);
      check("reset_hex2", 32'(hex2), 32'h7F);
      check("reset_led", 32'(led), 32'd1);
      check("reset_finished", 32'(finished), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].pc, vecs[i].clr, vecs[i].we, vecs[i].sel, vecs[i].lo, vecs[i].hi,
               vecs[i].sw);
         check($sformatf("vec%0d_rd_count", i), rd_count, vecs[i].exp_cnt);
         check($sformatf("vec%0d_hex0", i), 32'(hex0), 32'(hexd(vecs[i].exp_dig)));
         check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      end

      // Reconfigure a live channel, then clear and configure in the same cycle.
      drive(16'd11, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd1);
      check("clear_rd", rd_count, 32'd0);
      for (int i = 0; i < 37; i++) tick(16'(12 + (i % 2)), 4'd1);
      check("ch1_count37", rd_count, 32'd37);
      drive(16'd14, 1'b0, 1'b1, 3'd1, 16'd10, 16'd20, 4'd1);
      check("cfg_zeroes_ch1", rd_count, 32'd0);
      tick(16'd15, 4'd1);
      check("ch1_counts_after_cfg", rd_count, 32'd1);
      drive(16'd45, 1'b1, 1'b1, 3'd2, 16'd40, 16'd50, 4'd1);
      check("clr_cfg_ch1_zero", rd_count, 32'd0);
      tick(16'd46, 4'd2);
      check("clr_cfg_new_window", rd_count, 32'd1);
      tick(16'd47, 4'd1);
      check("ch1_outside", rd_count, 32'd0);
      tick(16'd48, 4'd4);
      check("cycle_after_clr", rd_count, 32'd3);

      // Window sweep, then the final PC freezes everything.
      drive(16'd80, 1'b1, 1'b1, 3'd0, 16'd100, 16'd199, 4'd0);
      for (int p = 90; p <= 209; p++) tick(16'(p), 4'd0);
      check("sweep_ch0", rd_count, 32'd100);
      check("sweep_not_done", 32'(finished), 32'd0);
      tick(FinalPc, 4'd0);
      check("done_finished", 32'(finished), 32'd1);
      check("done_led", 32'(led), 32'd2);
      for (int i = 0; i < 4; i++) tick(16'(150 + i), 4'd4);
      check("done_cycle_frozen", rd_count, 32'd121);
      check("done_still", 32'(finished), 32'd1);
      tick(16'd160, 4'd0);
      check("done_ch0_frozen", rd_count, 32'd100);

      // Asynchronous reset in the middle of a cycle while DONE.
      #3 reset = 1'b1;
      model_reset();
      #1;
      check("async_rd", rd_count, 32'd0);
      check("async_hex0", 32'(hex0), 32'h7F);
      check("async_hex1", 32'(hex1), 32'h7F);
      check("async_led", 32'(led), 32'd1);
      check("async_finished", 32'(finished), 32'd0);
      #2 reset = 1'b0;
      tick(16'd200, 4'd4);
      check("resume_cycle", rd_count, 32'd1);
      check("resume_led", 32'(led), 32'd1);

      // Stall detection after 16 equal samples.
      drive(16'd50, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd4);
      for (int i = 0; i < 15; i++) tick(16'd50, 4'd4);
      check("stall_not_yet", 32'(led), 32'd1);
      tick(16'd50, 4'd4);
      check("stall_led", 32'(led), 32'd4);
      check("stall_finished", 32'(finished), 32'd1);
      check("stall_cycle", rd_count, 32'd16);
      for (int i = 0; i < 3; i++) tick(16'(51 + i), 4'd4);
      check("stall_sticky", 32'(led), 32'd4);
      check("stall_frozen", rd_count, 32'd16);
      drive(16'd60, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd4);
      check("stall_clear_led", 32'(led), 32'd1);
      check("stall_clear_rd", rd_count, 32'd0);

      // Saturation on the 12-bit instance.
      drive(16'd0, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd4);
      for (int i = 0; i < 5000; i++) tick(16'((i % 900) + 1), 4'd4);
      check("sat_rd", 32'(s_rd), 32'hFFF);
      check("wide_rd", rd_count, 32'd5000);
      tick(16'd7, 4'd4);
      check("sat_hex0", 32'(s_hex0), 32'(hexd(4'hF)));
      check("sat_hex1", 32'(s_hex1), 32'(hexd(4'hF)));
      check("sat_hex2", 32'(s_hex2), 32'(hexd(4'hF)));
      tick(16'd8, 4'd12);
      check("sat_upper_hex0", 32'(s_hex0), 32'(hexd(4'h0)));
      check("wide_upper_hex0", 32'(hex0), 32'(hexd(4'h1)));
      check("wide_upper_hex1", 32'(hex1), 32'(hexd(4'h0)));

      // Randomized traffic against the model.
      last_p = 16'd8;
      hold_left = 0;
      for (int i = 0; i < 2000; i++) begin
         if (hold_left > 0) begin
            hold_left--;
            rp = last_p;
         end else begin
            case ($urandom_range(0, 99)) inside
               [0:5]:   begin hold_left = int'($urandom_range(10, 20)); rp = last_p; end
               [6:7]:   rp = FinalPc;
               default: rp = 16'($urandom_range(0, 300));
            endcase
         end
         rc = (m_state != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
         rw = ($urandom_range(0, 19) == 0);
         drive(rp, rc, rw, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 300)),
               16'($urandom_range(0, 300)), 4'($urandom_range(0, 15)));
         last_p = rp;
         model_check();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
